// File: rtl/ssd1306_spi_sequencer_if.sv
// Write port and shift-register/panel signals of the SSD1306 SPI sequencer.
interface ssd1306_spi_sequencer_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned FIFO_DEPTH = 4
);

  localparam int unsigned LEVEL_W = $clog2(FIFO_DEPTH + 1);

  logic               wr_valid_in;
  logic               wr_dc_in;
  logic [WIDTH-1:0]   wr_data_in;
  logic               wr_ready_out;
  logic               sr_ready_in;
  logic               sr_start_out;
  logic [WIDTH-1:0]   sr_data_out;
  logic               cs_n_out;
  logic               dc_out;
  logic               busy_out;
  logic [LEVEL_W-1:0] level_out;

  // Sequencer side
  modport slave (
    input  wr_valid_in, wr_dc_in, wr_data_in, sr_ready_in,
    output wr_ready_out, sr_start_out, sr_data_out, cs_n_out, dc_out,
           busy_out, level_out
  );

  // Frame logic / shift register side
  modport master (
    output wr_valid_in, wr_dc_in, wr_data_in, sr_ready_in,
    input  wr_ready_out, sr_start_out, sr_data_out, cs_n_out, dc_out,
           busy_out, level_out
  );

endinterface

// File: rtl/ssd1306_spi_sequencer.sv
// Buffers {dc, byte} words and sequences SSD1306 SPI transfers with cs_n/dc framing.
module ssd1306_spi_sequencer #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned CS_SETUP_CYCLES = 2,
  parameter int unsigned CS_HOLD_CYCLES  = 2
) (
  input logic                    clk_in,
  input logic                    reset_in,
  ssd1306_spi_sequencer_if.slave bus
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned LEVEL_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CNT_MAX = (CS_SETUP_CYCLES > CS_HOLD_CYCLES) ?
                                    CS_SETUP_CYCLES : CS_HOLD_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    ISSUE,
    LAUNCH,
    SHIFT,
    CS_HOLD
  } state_t;

  logic [WIDTH-1:0]   mem_data [FIFO_DEPTH];
  logic               mem_dc   [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LEVEL_W-1:0] level;
  logic [LEVEL_W-1:0] level_nxt;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               head_dc;
  logic [WIDTH-1:0]   head_data;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               cs_n_q;
  logic               cs_n_nxt;
  logic               dc_q;
  logic               dc_nxt;
  logic               start_q;
  logic               start_nxt;
  logic [WIDTH-1:0]   data_q;
  logic [WIDTH-1:0]   data_nxt;
  logic               busy_q;
  logic               busy_nxt;

  // FIFO flags; the write port is closed while full or in reset
  assign full             = (level == LEVEL_W'(FIFO_DEPTH));
  assign empty            = (level == '0);
  assign bus.wr_ready_out = !full && !reset_in;
  assign push             = bus.wr_valid_in && bus.wr_ready_out;
  assign head_dc          = mem_dc[rd_ptr];
  assign head_data        = mem_data[rd_ptr];

  // Occupancy update; simultaneous push and pop leave it unchanged
  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + LEVEL_W'(1);
      2'b01:   level_nxt = level - LEVEL_W'(1);
      default: level_nxt = level;
    endcase
  end

  // FIFO storage, no reset needed since occupancy guards every read
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_data[wr_ptr] <= bus.wr_data_in;
      mem_dc[wr_ptr]   <= bus.wr_dc_in;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_nxt;
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state   <= IDLE;
      cnt     <= '0;
      cs_n_q  <= 1'b1;
      dc_q    <= 1'b0;
      start_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cs_n_q  <= cs_n_nxt;
      dc_q    <= dc_nxt;
      start_q <= start_nxt;
      data_q  <= data_nxt;
      busy_q  <= busy_nxt;
    end
  end

  // Next state and next output values
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cs_n_nxt  = cs_n_q;
    dc_nxt    = dc_q;
    start_nxt = 1'b0;
    data_nxt  = data_q;
    pop       = 1'b0;

    case (state)
      IDLE: begin
        cs_n_nxt = 1'b1;
        if (!empty) begin
          dc_nxt    = head_dc;
          cs_n_nxt  = 1'b0;
          cnt_nxt   = CNT_W'(CS_SETUP_CYCLES);
          state_nxt = CS_SETUP;
        end
      end

      CS_SETUP: begin
        if (cnt <= CNT_W'(1)) begin
          state_nxt = ISSUE;
          if (bus.sr_ready_in) begin
            start_nxt = 1'b1;
            data_nxt  = head_data;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

      // start_q high means the pulse is on the bus this cycle; otherwise wait for the shifter
      ISSUE: begin
        if (start_q) begin
          pop       = 1'b1;
          state_nxt = LAUNCH;
        end else if (bus.sr_ready_in) begin
          start_nxt = 1'b1;
          data_nxt  = head_data;
        end
      end

      // Shifter drops ready a cycle after start, so ready is not trusted here
      LAUNCH: begin
        state_nxt = SHIFT;
      end

      SHIFT: begin
        if (bus.sr_ready_in) begin
          if (!empty && (head_dc == dc_q)) begin
            state_nxt = ISSUE;
            start_nxt = 1'b1;
            data_nxt  = head_data;
          end else begin
            cnt_nxt   = CNT_W'(CS_HOLD_CYCLES);
            state_nxt = CS_HOLD;
          end
        end
      end

      CS_HOLD: begin
        if (cnt <= CNT_W'(1)) begin
          cs_n_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

      default: begin
        cs_n_nxt  = 1'b1;
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE) || (level_nxt != '0);
  end

  assign bus.sr_start_out = start_q;
  assign bus.sr_data_out  = data_q;
  assign bus.cs_n_out     = cs_n_q;
  assign bus.dc_out       = dc_q;
  assign bus.busy_out     = busy_q;
  assign bus.level_out    = level;

endmodule
